// File: rtl/handshake_demux.sv
// handshake_demux: four-phase req/ack demultiplexer.
// One upstream channel is forwarded to one of COUNT downstream channels chosen
// by a destination captured with the request. The upstream handshake completes
// only after the downstream handshake has closed. Out-of-range destinations are
// acknowledged locally, dropped and counted with a saturating counter.
module handshake_demux #(
    parameter int COUNT      = 5,
    parameter int COUNT_BITS = 3,
    parameter int DATA_BITS  = 8,
    parameter int DROP_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_in,
    output logic                  ack_in,
    input  logic [COUNT_BITS-1:0] sel_in,
    input  logic [DATA_BITS-1:0]  data_in,
    output logic [COUNT-1:0]      reqs_out,
    input  logic [COUNT-1:0]      acks_out,
    output logic [DATA_BITS-1:0]  data_out,
    output logic [COUNT_BITS-1:0] selected,
    output logic                  busy,
    output logic [DROP_BITS-1:0]  drop_count
);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        HOLD,
        REL,
        DROP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [COUNT-1:0] in_onehot;
    logic [COUNT-1:0] sel_onehot;
    logic             sel_valid;
    logic             sel_ack;

    logic             capture;
    logic             drop_inc;
    logic             ack_in_nxt;
    logic             busy_nxt;
    logic [COUNT-1:0] reqs_out_nxt;

    // Decode the incoming and the latched destination into one-hot channel masks
    always_comb begin
        in_onehot  = '0;
        sel_onehot = '0;
        for (int i = 0; i < COUNT; i++) begin
            in_onehot[i]  = (sel_in == COUNT_BITS'(i));
            sel_onehot[i] = (selected == COUNT_BITS'(i));
        end
    end

    // An out-of-range destination matches no channel; only the latched
    // channel's acknowledge is ever looked at.
    assign sel_valid = |in_onehot;
    assign sel_ack   = |(acks_out & sel_onehot);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: each transition fires on the first edge its level is seen
    always_comb begin
        // NOTE: the default assignment first keeps this block from inferring a
        // latch on paths that do not mention state_nxt.
        state_nxt = state;
        case (state)
            IDLE: if (req_in)   state_nxt = sel_valid ? FWD : DROP;
            FWD:  if (sel_ack)  state_nxt = HOLD;
            HOLD: if (!req_in)  state_nxt = REL;
            REL:  if (!sel_ack) state_nxt = IDLE;
            DROP: if (!req_in)  state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the next state
    always_comb begin
        capture      = (state == IDLE) && req_in;
        drop_inc     = capture && !sel_valid && (drop_count != '1);
        busy_nxt     = (state_nxt != IDLE);
        ack_in_nxt   = (state_nxt == HOLD) || (state_nxt == REL) || (state_nxt == DROP);
        reqs_out_nxt = '0;
        if ((state_nxt == FWD) || (state_nxt == HOLD)) begin
            // On the accepting edge the latch is not loaded yet, so use sel_in.
            reqs_out_nxt = (state == IDLE) ? in_onehot : sel_onehot;
        end
    end

    // Output and capture registers; reset clears downstream requests at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_in     <= 1'b0;
            reqs_out   <= '0;
            data_out   <= '0;
            selected   <= '0;
            busy       <= 1'b0;
            drop_count <= '0;
        end else begin
            ack_in   <= ack_in_nxt;
            reqs_out <= reqs_out_nxt;
            busy     <= busy_nxt;
            if (capture) begin
                selected <= sel_in;
                data_out <= data_in;
            end
            if (drop_inc) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_demux.sv
// Directed bench for handshake_demux: routed, back-to-back, dropped, stale and
// unselected acknowledges, mid-transfer input changes and reset abort.
module tb_handshake_demux;

    localparam int COUNT      = 5;
    localparam int COUNT_BITS = 3;
    localparam int DATA_BITS  = 8;
    localparam int DROP_BITS  = 8;

    logic                  clk;
    logic                  reset;
    logic                  req_in;
    logic                  ack_in;
    logic [COUNT_BITS-1:0] sel_in;
    logic [DATA_BITS-1:0]  data_in;
    logic [COUNT-1:0]      reqs_out;
    logic [COUNT-1:0]      acks_out;
    logic [DATA_BITS-1:0]  data_out;
    logic [COUNT_BITS-1:0] selected;
    logic                  busy;
    logic [DROP_BITS-1:0]  drop_count;

    typedef struct packed {
        logic [COUNT_BITS-1:0] ch;
        logic [DATA_BITS-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    handshake_demux #(
        .COUNT     (COUNT),
        .COUNT_BITS(COUNT_BITS),
        .DATA_BITS (DATA_BITS),
        .DROP_BITS (DROP_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .ack_in    (ack_in),
        .sel_in    (sel_in),
        .data_in   (data_in),
        .reqs_out  (reqs_out),
        .acks_out  (acks_out),
        .data_out  (data_out),
        .selected  (selected),
        .busy      (busy),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [COUNT-1:0] onehot(input int c);
        logic [COUNT-1:0] m;
        m    = '0;
        m[c] = 1'b1;
        return m;
    endfunction

    // Advance one edge, sample 1 ns later, and check at most one request is up.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot0", 32'($countones(reqs_out) <= 1), 32'd1);
    endtask

    // One routed transfer; responder acks after ack_dly extra cycles and
    // releases rel_dly cycles after it sees the request fall.
    task automatic do_xfer(input int ch, input logic [DATA_BITS-1:0] d,
                           input int ack_dly, input int rel_dly);
        exp_t e;
        sb.push_back(exp_t'{ch: COUNT_BITS'(ch), data: d});
        req_in  = 1'b1;
        sel_in  = COUNT_BITS'(ch);
        data_in = d;
        tick();
        check("req_rise", reqs_out, onehot(ch));
        check("busy_rise", busy, 1'b1);
        check("ack_idle", ack_in, 1'b0);
        check("sb_avail", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_sel", selected, e.ch);
            check("sb_data", data_out, e.data);
        end
        repeat (ack_dly) begin
            tick();
            check("ack_wait", ack_in, 1'b0);
            check("req_hold", reqs_out, onehot(ch));
        end
        acks_out[ch] = 1'b1;
        tick();
        check("ack_rise", ack_in, 1'b1);
        check("req_in_hold", reqs_out, onehot(ch));
        check("data_hold", data_out, d);
        req_in = 1'b0;
        tick();
        check("req_fall", reqs_out, '0);
        check("ack_held", ack_in, 1'b1);
        check("data_rel", data_out, d);
        repeat (rel_dly) begin
            tick();
            check("ack_rel_wait", ack_in, 1'b1);
            check("busy_rel", busy, 1'b1);
        end
        acks_out[ch] = 1'b0;
        tick();
        check("ack_fall", ack_in, 1'b0);
        check("busy_fall", busy, 1'b0);
    endtask

    // One dropped transfer to an out-of-range destination.
    task automatic do_drop(input logic [COUNT_BITS-1:0] s, input logic [DROP_BITS-1:0] exp_cnt,
                           input bit full);
        req_in  = 1'b1;
        sel_in  = s;
        data_in = 8'h77;
        tick();
        if (full) begin
            check("drop_req", reqs_out, '0);
            check("drop_ack", ack_in, 1'b1);
            check("drop_busy", busy, 1'b1);
            check("drop_cnt", drop_count, exp_cnt);
        end
        req_in = 1'b0;
        tick();
        if (full) begin
            check("drop_ack_fall", ack_in, 1'b0);
            check("drop_idle", busy, 1'b0);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        req_in   = 1'b0;
        sel_in   = '0;
        data_in  = '0;
        acks_out = '0;
        #23;
        check("rst_ack", ack_in, 1'b0);
        check("rst_reqs", reqs_out, '0);
        check("rst_data", data_out, '0);
        check("rst_sel", selected, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_count, '0);
        reset = 1'b1;
        tick();

        // Routed transfer to channel 2, ack 2 cycles after req.
        do_xfer(2, 8'hA5, 1, 0);

        // Back-to-back with zero-delay responders.
        do_xfer(0, 8'h11, 0, 0);
        do_xfer(4, 8'h44, 0, 0);
        do_xfer(0, 8'h22, 0, 0);

        // Invalid destination, then saturation after 300 drops.
        do_drop(3'd6, 8'd1, 1'b1);
        for (int i = 1; i < 300; i++) begin
            do_drop((i % 2 == 0) ? 3'd6 : 3'd7, 8'(i + 1), 1'b0);
        end
        check("drop_sat", drop_count, 8'hFF);
        do_drop(3'd5, 8'hFF, 1'b1);

        // Unselected ack ignored, mid-transfer sel/data changes ignored.
        req_in  = 1'b1;
        sel_in  = 3'd1;
        data_in = 8'hC3;
        tick();
        check("fwd_req1", reqs_out, onehot(1));
        acks_out[3] = 1'b1;
        tick();
        check("unsel_ack", ack_in, 1'b0);
        check("unsel_req", reqs_out, onehot(1));
        acks_out[3] = 1'b0;
        sel_in      = 3'd3;
        data_in     = 8'h3C;
        tick();
        check("mid_sel", selected, 3'd1);
        check("mid_data", data_out, 8'hC3);
        check("mid_req", reqs_out, onehot(1));
        acks_out[1] = 1'b1;
        tick();
        check("sel_ack", ack_in, 1'b1);
        req_in = 1'b0;
        tick();
        acks_out[1] = 1'b0;
        tick();
        check("mid_idle", busy, 1'b0);

        // Stale ack: already high before request, HOLD one edge after FWD.
        acks_out[1] = 1'b1;
        req_in      = 1'b1;
        sel_in      = 3'd1;
        data_in     = 8'h99;
        tick();
        check("stale_fwd", reqs_out, onehot(1));
        check("stale_noack", ack_in, 1'b0);
        tick();
        check("stale_hold", ack_in, 1'b1);

        // Reset asserted in HOLD aborts immediately, without waiting for an edge.
        #2;
        reset = 1'b0;
        #1;
        check("abort_reqs", reqs_out, '0);
        check("abort_ack", ack_in, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_data", data_out, '0);
        check("abort_sel", selected, '0);
        check("abort_drop", drop_count, '0);
        req_in   = 1'b0;
        acks_out = '0;
        #2;
        reset = 1'b1;
        tick();

        // Normal transfer to channel 3 after release.
        do_xfer(3, 8'h5A, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/handshake_demux.md
# handshake_demux

Four-phase req/ack demultiplexer: accepts transfers on one upstream channel and forwards each to one of `COUNT` downstream channels selected by a destination field sampled with the request. It sits at a router output stage, opposite the round-robin arbiter that merges many channels into one. It latches the transfer's payload and destination, drives exactly one downstream request, and completes the upstream handshake only after the downstream handshake has closed. Destinations outside the range are acknowledged locally, dropped and counted.

## Interface

- `COUNT`, 5, number of downstream channels.
- `COUNT_BITS`, 3, width of destination field; 2^COUNT_BITS >= COUNT.
- `DATA_BITS`, 8, payload width.
- `DROP_BITS`, 8, width of drop counter.

- `clk` input 1: the block's one clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; block held in reset while 0.
- `req_in` input 1: upstream four-phase request.
- `ack_in` output 1: upstream acknowledge.
- `sel_in` input COUNT_BITS: destination; valid while `req_in`=1.
- `data_in` input DATA_BITS: payload; valid while `req_in`=1.
- `reqs_out` output COUNT: downstream requests, at most one bit set at a time.
- `acks_out` input COUNT: downstream acknowledges.
- `data_out` output DATA_BITS: latched payload, stable for the whole downstream handshake.
- `selected` output COUNT_BITS: latched destination.
- `busy` output 1: 1 in every state except IDLE.
- `drop_count` output DROP_BITS: saturating count of dropped transfers.

## Operation

- All outputs are registered. Reset values: `ack_in`=0, `reqs_out`=0, `data_out`=0, `selected`=0, `busy`=0, `drop_count`=0, state IDLE.
- Reset assertion in any state aborts the transfer immediately. All downstream requests drop asynchronously. No completion is signalled upstream.
- IDLE: if `req_in`=1, latch `sel_in` into `selected` and `data_in` into `data_out`.
  - If `sel_in` < COUNT: set `reqs_out[sel_in]` and go to FWD.
  - Otherwise: set `ack_in`, increment `drop_count` (saturate at all-ones) and go to DROP.
- FWD: hold `reqs_out[selected]`=1. When `acks_out[selected]`=1, set `ack_in`=1 and go to HOLD.
- HOLD: when `req_in`=0, clear `reqs_out[selected]` and go to REL.
- REL: when `acks_out[selected]`=0, clear `ack_in` and go to IDLE.
- DROP: hold `ack_in`=1. When `req_in`=0, clear `ack_in` and go to IDLE.
- Rules on the acknowledge inputs:
  - `acks_out` bits other than `selected` are ignored in every state.
  - All acknowledges are level-sensitive; no edge detection.
- Changes on `sel_in` and `data_in` after the IDLE capture are ignored until the next IDLE.
- Upstream protocol violation (`req_in` falls in FWD): the block stays in FWD. It raises `ack_in` once the downstream acknowledge arrives, then passes through HOLD in one cycle.

## Timing

- Each transition occurs on the first rising edge at which its condition is sampled true. Outputs change at that edge.
- `req_in`↑ sampled → `reqs_out[sel]`↑: 1 cycle.
- `acks_out[sel]`↑ sampled → `ack_in`↑: 1 cycle.
- `req_in`↓ sampled → `reqs_out[sel]`↓: 1 cycle.
- `acks_out[sel]`↓ sampled → `ack_in`↓: 1 cycle.
- Minimum full transfer with zero-delay responders: 4 edges. A new request may be accepted on the edge after returning to IDLE, i.e. 1 cycle of IDLE at minimum.
- Stale high ack: if `acks_out[sel]` is already 1 when FWD is entered, HOLD is entered on the next edge.
- Dropped transfer: `ack_in` rises 1 cycle after `req_in`, and falls 1 cycle after `req_in` falls.
- `drop_count` updates on the same edge as the DROP entry.
- `busy` rises with the IDLE→FWD/DROP edge and falls with the REL/DROP→IDLE edge.

## Test plan

- Routed transfer: `sel_in`=2, `data_in`=0xA5. Responder acks 2 cycles after req and releases 1 cycle after req falls.
  - Required: only `reqs_out[2]` toggles; `data_out`=0xA5 throughout; `ack_in` rises 1 cycle after `acks_out[2]`; `busy` returns to 0.
- Back-to-back transfers to channels 0, 4, 0 with zero-delay responders.
  - Required: each transfer takes 4 edges plus 1 IDLE cycle; `reqs_out` never has two bits set.
- Invalid destination: `sel_in`=6 with COUNT=5.
  - Required: `reqs_out` stays 0; `ack_in`↑ after 1 cycle; `drop_count`=1.
  - Repeating 300 times leaves `drop_count` saturated at 255.
- Unselected ack and stale ack:
  - With `sel_in`=1, toggling `acks_out[3]` has no effect.
  - With `acks_out[1]` held at 1 before the request, FWD→HOLD occurs in 1 cycle.
- Mid-transfer behaviour:
  - Change `sel_in`/`data_in` during FWD: `selected` and `data_out` are unchanged.
  - Assert `reset`=0 in HOLD: all outputs return to reset values immediately.
  - After release, a new transfer to channel 3 completes normally.
